// File: rtl/sram_if_monitor.sv
// sram_if_monitor
//   Passive protocol monitor for NCH SRAM-style memory ports. For each channel
//   it checks that a request is held stable while stalled, that write strobes
//   are non-empty and form one naturally aligned group, and that a stall does
//   not last MAX_STALL cycles. Violations set sticky flags, and the first one
//   is recorded. Completed transactions, and completions with mem_error set,
//   are counted with saturating counters.
// Ports
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   clr             : synchronous clear of sticky flags, first record, counters
//   mem_cen/wen/stall/error [NCH]      : per-channel control
//   mem_strb [NCH*SB], mem_addr [NCH*AW], mem_wdata [NCH*DW] : per-channel request
//   viol_sticky [NCH*4]                : sticky flags, bit index = violation code
//   first_valid, first_ch, first_code  : first recorded violation
//   txn_count, err_count [NCH*CW]      : saturating per-channel counters
module sram_if_monitor #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned CW        = 16,
  localparam int unsigned SB       = DW / 8,
  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              clr,
  input  logic [NCH-1:0]    mem_cen,
  input  logic [NCH-1:0]    mem_wen,
  input  logic [NCH-1:0]    mem_stall,
  input  logic [NCH-1:0]    mem_error,
  input  logic [NCH*SB-1:0] mem_strb,
  input  logic [NCH*AW-1:0] mem_addr,
  input  logic [NCH*DW-1:0] mem_wdata,
  output logic [NCH*4-1:0]  viol_sticky,
  output logic              first_valid,
  output logic [CHW-1:0]    first_ch,
  output logic [1:0]        first_code,
  output logic [NCH*CW-1:0] txn_count,
  output logic [NCH*CW-1:0] err_count
);

  localparam int unsigned LB  = $clog2(SB);
  localparam int unsigned SCW = $clog2(MAX_STALL + 1);
  localparam logic [SCW-1:0] SMAX    = SCW'(MAX_STALL);
  localparam logic [SCW-1:0] SMAX_M1 = SCW'(MAX_STALL - 1);
  localparam logic [SCW-1:0] SONE    = SCW'(1);
  localparam logic [CW-1:0]  CONE    = CW'(1);
  localparam logic [LB:0]    PONE    = (LB + 1)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } pend_e;

  pend_e          state_q     [NCH];
  pend_e          state_d     [NCH];
  logic           cap_wen_q   [NCH];
  logic [SB-1:0]  cap_strb_q  [NCH];
  logic [AW-1:0]  cap_addr_q  [NCH];
  logic [DW-1:0]  cap_wdata_q [NCH];
  logic [SCW-1:0] scnt_q      [NCH];
  logic [SCW-1:0] scnt_d      [NCH];
  logic [SCW-1:0] scnt_prev   [NCH];
  logic           load        [NCH];
  logic [3:0]     viol        [NCH];
  logic [3:0]     sticky_q    [NCH];
  logic [3:0]     sticky_d    [NCH];
  logic [CW-1:0]  txn_q       [NCH];
  logic [CW-1:0]  txn_d       [NCH];
  logic [CW-1:0]  err_q       [NCH];
  logic [CW-1:0]  err_d       [NCH];

  logic           first_valid_q;
  logic [CHW-1:0] first_ch_q;
  logic [1:0]     first_code_q;
  logic           sel_found;
  logic [CHW-1:0] sel_ch;
  logic [1:0]     sel_code;

  // Legal strobe: one contiguous run of power-of-two length whose lowest lane
  // equals the byte offset, with the offset a multiple of the run length.
  function automatic logic strb_legal(input logic [SB-1:0] strb,
                                      input logic [LB-1:0] alo);
    logic [LB:0]   pc;
    logic [LB-1:0] low;
    logic          found;
    logic [SB-1:0] mask;
    pc    = '0;
    low   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < SB; i++) begin
      if (strb[i]) begin
        pc = pc + PONE;
        if (!found) begin
          low   = LB'(i);
          found = 1'b1;
        end
      end
    end
    mask = '0;
    for (int unsigned i = 0; i < SB; i++) begin
      mask[i] = (i >= 32'(low)) && (i < 32'(low) + 32'(pc));
    end
    // pc == SB truncates to 0, so the offset mask becomes all ones: offset must be 0.
    return found && ((pc & (pc - PONE)) == '0) && (mask == strb) && (low == alo)
           && ((alo & (pc[LB-1:0] - LB'(1))) == '0);
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      viol[c]      = '0;
      state_d[c]   = state_q[c];
      scnt_d[c]    = scnt_q[c];
      load[c]      = 1'b0;
      scnt_prev[c] = (state_q[c] == S_HELD) ? scnt_q[c] : '0;

      if (state_q[c] == S_HELD) begin
        viol[c][0] = !mem_cen[c]
                   || (mem_wen[c] != cap_wen_q[c])
                   || (mem_addr[c*AW +: AW] != cap_addr_q[c])
                   || (cap_wen_q[c] && ((mem_strb[c*SB +: SB] != cap_strb_q[c])
                                     || (mem_wdata[c*DW +: DW] != cap_wdata_q[c])));
      end
      viol[c][1] = mem_cen[c] && mem_wen[c] && (mem_strb[c*SB +: SB] == '0);
      viol[c][2] = mem_cen[c] && mem_wen[c] && (mem_strb[c*SB +: SB] != '0)
                   && !strb_legal(mem_strb[c*SB +: SB], mem_addr[c*AW +: LB]);

      if (mem_cen[c] && mem_stall[c]) begin
        state_d[c] = S_HELD;
        load[c]    = (state_q[c] == S_IDLE);
        scnt_d[c]  = (scnt_prev[c] == SMAX) ? SMAX : scnt_prev[c] + SONE;
        // Saturating at MAX_STALL means the previous count equals MAX_STALL-1
        // exactly once per request.
        viol[c][3] = (scnt_prev[c] == SMAX_M1);
      end else begin
        state_d[c] = S_IDLE;
        scnt_d[c]  = '0;
      end

      // Clear first, then apply this cycle's events so new data wins over clr.
      sticky_d[c] = (clr ? 4'b0 : sticky_q[c]) | viol[c];
      txn_d[c]    = clr ? '0 : txn_q[c];
      err_d[c]    = clr ? '0 : err_q[c];
      if (mem_cen[c] && !mem_stall[c]) begin
        if (txn_d[c] != '1) txn_d[c] = txn_d[c] + CONE;
        if (mem_error[c] && (err_d[c] != '1)) err_d[c] = err_d[c] + CONE;
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_code  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (!sel_found && viol[c][k]) begin
          sel_found = 1'b1;
          sel_ch    = CHW'(c);
          sel_code  = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c]     <= S_IDLE;
        scnt_q[c]      <= '0;
        cap_wen_q[c]   <= 1'b0;
        cap_strb_q[c]  <= '0;
        cap_addr_q[c]  <= '0;
        cap_wdata_q[c] <= '0;
        sticky_q[c]    <= '0;
        txn_q[c]       <= '0;
        err_q[c]       <= '0;
      end
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_code_q  <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c]  <= state_d[c];
        scnt_q[c]   <= scnt_d[c];
        sticky_q[c] <= sticky_d[c];
        txn_q[c]    <= txn_d[c];
        err_q[c]    <= err_d[c];
        if (load[c]) begin
          cap_wen_q[c]   <= mem_wen[c];
          cap_strb_q[c]  <= mem_strb[c*SB +: SB];
          cap_addr_q[c]  <= mem_addr[c*AW +: AW];
          cap_wdata_q[c] <= mem_wdata[c*DW +: DW];
        end
      end
      if (clr || !first_valid_q) begin
        first_valid_q <= sel_found;
        first_ch_q    <= sel_found ? sel_ch : '0;
        first_code_q  <= sel_found ? sel_code : '0;
      end
    end
  end

  always_comb begin
    viol_sticky = '0;
    txn_count   = '0;
    err_count   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      viol_sticky[c*4 +: 4]  = sticky_q[c];
      txn_count[c*CW +: CW]  = txn_q[c];
      err_count[c*CW +: CW]  = err_q[c];
    end
    first_valid = first_valid_q;
    first_ch    = first_ch_q;
    first_code  = first_code_q;
  end

endmodule
